dm_resp_4k: RTL and testbench

//  Wait-stated 4 KB data-memory responder for the MIPS MEM stage bus.
//  The pipeline is the initiator: it issues load/store requests over a valid/ready request channel.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/dm_resp_4k_if.sv | 33 +++
 rtl/dm_bytelane_ram.sv | 29 ++
 rtl/dm_resp_4k.sv | 131 +++++++++++++
 tb/tb_dm_resp_4k.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: size codes, responder FSM states, alignment helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mips_pkg;

  // Same coding as the pipeline's SWSrc field.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } dm_state_e;

  // Reserved size is always rejected; bytes can never be misaligned.
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return (a != 2'b00);
      SZ_HALF: return a[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_resp_4k_if.sv
// MEM-stage data bus: valid/ready request channel and valid/ready response channel.
// Latency: n/a (wires only).
// Backpressure: req_ready stalls the initiator, resp_ready stalls the responder.
// Ports: req_valid/req_ready/req_we/req_size/req_addr/req_wdata,
//        resp_valid/resp_ready/resp_rdata/resp_err.
interface dm_resp_4k_if #(
  parameter int ADDR_W = 12
) ();
  import mips_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Pipeline side.
  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory responder side.
  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_bytelane_ram.sv
// Single-port word RAM with per-byte write enables.
// Latency: 1 cycle, rdata registered on an enabled cycle (returns the pre-write word).
// Backpressure: none; rdata holds its value while en is low.
// Ports: clk, en, be[3:0], idx, wdata, rdata.
module dm_bytelane_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  // Contents are deliberately not reset.
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dm_resp_4k.sv
// Wait-stated 4 KB data-memory responder for the MEM stage: latch request, stall, access, respond.
// Latency: WAIT_CYCLES+1 cycles from request accept to resp_valid.
// Backpressure: one request in flight; req_ready low from accept until the response handshake.
// Ports: clk, rst (sync, active-low), bus (dm_resp_4k_if.slave).
module dm_resp_4k
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  dm_resp_4k_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  // The WAIT state spends WAIT_CYCLES stall cycles, then one access cycle
  // whose RAM read lands exactly when resp_valid rises.
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

  dm_state_e         state;
  logic [3:0]        wait_cnt;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              resp_rd_q;     // response carries RAM read data

  logic              lat_we;
  size_e             lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              misal;
  logic              ram_en;
  logic              ram_wr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [IDX_W-1:0]  ram_idx;

  assign misal   = is_misaligned(lat_size, lat_addr[1:0]);
  // Higher address bits beyond the RAM depth are dropped, giving the wrap.
  assign ram_idx = IDX_W'(lat_addr[ADDR_W-1:2]);
  // Reset in the access cycle suppresses the write as well.
  assign ram_en  = rst && (state == S_WAIT) && (wait_cnt == CNT_LAST);
  assign ram_wr  = ram_en && lat_we && !misal;

  // Replicate right-aligned store data across lanes; the byte enables pick the target.
  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = lat_wdata;
    case (lat_size)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << lat_addr[1:0];
        ram_wdata = {4{lat_wdata[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{lat_wdata[15:0]}};
      end
      SZ_WORD: ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
    if (!ram_wr) ram_be = 4'b0000;
  end

  dm_bytelane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            lat_we      <= bus.req_we;
            lat_size    <= size_e'(bus.req_size);
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            wait_cnt    <= 4'd0;
            req_ready_q <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == CNT_LAST) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= misal;
            resp_rd_q    <= !lat_we && !misal;
            state        <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  // RAM output is itself a register and is not re-enabled while a response is held.
  assign bus.resp_rdata = resp_rd_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dm_resp_4k.sv
// Directed bench for dm_resp_4k: reset, word/sub-word stores, misalignment,
// backpressure, reset abort and address wrap.
// Ports: none (top-level bench).
module tb_dm_resp_4k;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  dm_resp_4k_if #(.ADDR_W(12)) bus ();

  dm_resp_4k #(
    .DEPTH_WORDS (1024),
    .ADDR_W      (12),
    .WAIT_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction; returns read data, error flag and accept->resp_valid cycles.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic [12:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int guard;
    rd = 32'h0; er = 1'b0; lat = 0; guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: req_ready=%b, required 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = addr[11:0];  // bits above ADDR_W are not carried by the bus
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.resp_valid === 1'b1) break;
    end
    if (lat >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: resp_valid=%b, required 1", bus.resp_valid);
      return;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.resp_err); end
    rst = 1'b1;
    // resp_ready with no response pending must do nothing.
    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      begin n_bad++; $display("FAIL idle_resp_ready: valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b00, 13'h010, 32'hDEADBEEF, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sw_latency: got %0d want 3", lat); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_resp: err=%b rdata=%h want 0/0", er, rd); end
    do_req(1'b0, 2'b00, 13'h010, 32'h0, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw_word: rdata=%h err=%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 13'h013, 32'hAABBCC55, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sb_err: got %b want 0", er); end
    do_req(1'b1, 2'b01, 13'h010, 32'hFFFF1234, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sh_err: got %b want 0", er); end
    do_req(1'b0, 2'b00, 13'h010, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h55AD1234) begin n_bad++; $display("FAIL lw_subword: got %h want 55ad1234", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b01, 13'h011, 32'h0000ABCD, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL sh_misal: err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 2'b00, 13'h002, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_misal: err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 2'b11, 13'h010, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL rsvd_load: err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b1, 2'b11, 13'h010, 32'h11111111, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL rsvd_store: err=%b want 1", er); end
    do_req(1'b0, 2'b00, 13'h010, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h55AD1234) begin n_bad++; $display("FAIL misal_no_write: got %h want 55ad1234", rd); end
    // Upper-half store at the highest aligned halfword offset is legal.
    do_req(1'b1, 2'b01, 13'h012, 32'h00009999, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sh_upper_err: got %b want 0", er); end
    do_req(1'b0, 2'b00, 13'h010, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h99991234) begin n_bad++; $display("FAIL sh_upper: got %h want 99991234", rd); end
  endtask

  task automatic test_backpressure();
    int guard; int bad_hold; int lat;
    logic [31:0] rd0;
    bad_hold = 0; guard = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_addr = 12'h010; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    // Leave req_valid asserted: the responder must not take a second request while busy.
    while (bus.resp_valid !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    n_cmp++; if (guard >= 50) begin n_bad++; $display("FAIL bp_timeout: resp_valid=%b want 1", bus.resp_valid); end
    rd0 = bus.resp_rdata;
    n_cmp++; if (rd0 !== 32'h99991234) begin n_bad++; $display("FAIL bp_rdata: got %h want 99991234", rd0); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd0 || bus.req_ready !== 1'b0) bad_hold++;
    end
    n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad_hold); end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
      begin n_bad++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid); end
    // The still-asserted request is taken on the next edge.
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.resp_valid === 1'b1) break;
    end
    n_cmp++; if (lat !== 3 || bus.resp_rdata !== 32'h99991234)
      begin n_bad++; $display("FAIL bp_next: lat=%0d rdata=%h want 3/99991234", lat, bus.resp_rdata); end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b00, 13'h020, 32'h11112222, rd, er, lat);
    // Accept a store, then reset during the first stall cycle.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 12'h020; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      begin n_bad++; $display("FAIL abort_state: valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
    do_req(1'b0, 2'b00, 13'h020, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h11112222) begin n_bad++; $display("FAIL abort_no_write: got %h want 11112222", rd); end
    // Handshake and reset on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 12'h020; bus.req_wdata = 32'h0BAD0BAD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wins_valid: got %b want 0", bus.resp_valid); end
    do_req(1'b0, 2'b00, 13'h020, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h11112222) begin n_bad++; $display("FAIL rst_wins_mem: got %h want 11112222", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b00, 13'h0FFC, 32'hA5A55A5A, rd, er, lat);
    do_req(1'b1, 2'b00, 13'h0000, 32'h01020304, rd, er, lat);
    do_req(1'b0, 2'b00, 13'h0FFC, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hA5A55A5A) begin n_bad++; $display("FAIL wrap_top: got %h want a5a55a5a", rd); end
    do_req(1'b0, 2'b00, 13'h1FFC, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hA5A55A5A) begin n_bad++; $display("FAIL wrap_alias: got %h want a5a55a5a", rd); end
    do_req(1'b0, 2'b00, 13'h1000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h01020304) begin n_bad++; $display("FAIL wrap_zero: got %h want 01020304", rd); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_addr = 12'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_backpressure();
    test_reset_midop();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
